// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Pipeline memory-access stage. Runs multi-cycle loads/stores
//               against an internal word memory, passes other ops through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       aluresult,
    input  logic [15:0]       instrin,
    input  logic [15:0]       op2_in,
    input  logic              isld,
    input  logic              isst,
    input  logic              iswb,
    input  logic              is_branch_takenin,
    output logic              wb_valid,
    output logic [15:0]       wb_data,
    output logic [15:0]       wb_instr,
    output logic              wb_en,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [15:0]       dbg_data
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] c_mem_lat = 4'(MEM_LAT);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         data_q;
    logic [15:0]         instr_q;
    logic                iswb_q;
    logic                ld_q;
    logic                st_q;
    logic                wb_valid_q;
    logic                wb_en_q;
    logic [15:0]         wb_data_q;
    logic [15:0]         wb_instr_q;

    logic [15:0]         mem [0:(1<<ADDR_W)-1];

    logic                w_accept;
    logic                w_is_mem;
    logic                w_done;

    assign in_ready = (state_q == IDLE);
    assign w_accept = in_valid & in_ready & ~is_branch_takenin;
    assign w_is_mem = isld | isst;
    assign w_done   = (state_q == BUSY) && (cnt_q == 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= 16'd0;
            instr_q    <= 16'd0;
            iswb_q     <= 1'b0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_data_q  <= 16'd0;
            wb_instr_q <= 16'd0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mem) begin
                            addr_q  <= aluresult[ADDR_W-1:0];
                            data_q  <= op2_in;
                            instr_q <= instrin;
                            iswb_q  <= iswb;
                            ld_q    <= isld;
                            // A combined load/store flag is a load; the store is dropped
                            st_q    <= isst & ~isld;
                            cnt_q   <= c_mem_lat;
                            state_q <= BUSY;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_en_q    <= iswb;
                            wb_data_q  <= aluresult;
                            wb_instr_q <= instrin;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_en_q    <= iswb_q & ~st_q;
                        wb_data_q  <= ld_q ? mem[addr_q] : data_q;
                        wb_instr_q <= instr_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write enable derives from reset-cleared state, so an aborted store never lands
    always_ff @(posedge clk) begin
        if (w_done && st_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_en    = wb_en_q;
    assign wb_data  = wb_data_q;
    assign wb_instr = wb_instr_q;
    assign dbg_data = mem[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Directed self-checking bench for mem_access (MEM_LAT 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid1 = 1'b0;
    logic [15:0] aluresult = 16'd0;
    logic [15:0] instrin = 16'd0;
    logic [15:0] op2_in = 16'd0;
    logic        isld = 1'b0;
    logic        isst = 1'b0;
    logic        iswb = 1'b0;
    logic        is_branch_takenin = 1'b0;
    logic [7:0]  dbg_addr = 8'd0;

    logic        in_ready, wb_valid, wb_en;
    logic [15:0] wb_data, wb_instr, dbg_data;
    logic        in_ready1, wb_valid1, wb_en1;
    logic [15:0] wb_data1, wb_instr1, dbg_data1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(8), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluresult(aluresult), .instrin(instrin), .op2_in(op2_in),
        .isld(isld), .isst(isst), .iswb(iswb), .is_branch_takenin(is_branch_takenin),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_instr(wb_instr), .wb_en(wb_en),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mem_access #(.ADDR_W(8), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .aluresult(aluresult), .instrin(instrin), .op2_in(op2_in),
        .isld(isld), .isst(isst), .iswb(iswb), .is_branch_takenin(is_branch_takenin),
        .wb_valid(wb_valid1), .wb_data(wb_data1), .wb_instr(wb_instr1), .wb_en(wb_en1),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [15:0] a, input logic [15:0] ins, input logic [15:0] d,
                          input logic ld, input logic st, input logic wb);
        aluresult = a; instrin = ins; op2_in = d; isld = ld; isst = st; iswb = wb;
    endtask

    // Issue one op on the MEM_LAT=2 instance and wait (bounded) for its completion
    task automatic mem_op(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic ld, input logic st);
        bit seen = 1'b0;
        set_op(a, 16'h0F00, d, ld, st, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (wb_valid) seen = 1'b1;
        end
        chk(tag, {15'd0, seen}, 16'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_wb_valid", {15'd0, wb_valid}, 16'd0);
        chk("rst_wb_en",    {15'd0, wb_en},    16'd0);
        chk("rst_wb_data",  wb_data,           16'd0);
        chk("rst_wb_instr", wb_instr,          16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        reset = 1'b1;
        tick();

        // Pass-through
        set_op(16'h1234, 16'hA001, 16'h0000, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pt_valid", {15'd0, wb_valid}, 16'd1);
        chk("pt_data",  wb_data,           16'h1234);
        chk("pt_en",    {15'd0, wb_en},    16'd1);
        chk("pt_instr", wb_instr,          16'hA001);
        tick();
        chk("pt_pulse", {15'd0, wb_valid}, 16'd0);

        // Back-to-back pass-through
        set_op(16'h1111, 16'hA002, 16'h0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        chk("b2b_v0", {15'd0, wb_valid}, 16'd1);
        chk("b2b_en0", {15'd0, wb_en}, 16'd0);
        set_op(16'h2222, 16'hA003, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b2b_v1", {15'd0, wb_valid}, 16'd1);
        chk("b2b_d1", wb_data, 16'h2222);

        // Store 5 <= BEEF
        set_op(16'h0005, 16'hB005, 16'hBEEF, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("st_rdy0", {15'd0, in_ready}, 16'd0);
        chk("st_v0",   {15'd0, wb_valid}, 16'd0);
        tick();
        chk("st_rdy1", {15'd0, in_ready}, 16'd0);
        chk("st_v1",   {15'd0, wb_valid}, 16'd0);
        tick();
        dbg_addr = 8'd5;
        #1;
        chk("st_rdy2", {15'd0, in_ready}, 16'd1);
        chk("st_v2",   {15'd0, wb_valid}, 16'd1);
        chk("st_data", wb_data, 16'hBEEF);
        chk("st_en",   {15'd0, wb_en}, 16'd0);
        chk("st_instr", wb_instr, 16'hB005);
        chk("st_mem5", dbg_data, 16'hBEEF);

        // Load 0x0105 wraps to 5
        set_op(16'h0105, 16'hC105, 16'h0000, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ld_v1", {15'd0, wb_valid}, 16'd0);
        tick();
        chk("ld_v2",   {15'd0, wb_valid}, 16'd1);
        chk("ld_data", wb_data, 16'hBEEF);
        chk("ld_en",   {15'd0, wb_en}, 16'd1);

        // in_valid held through BUSY
        set_op(16'h0007, 16'hB007, 16'h7777, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        set_op(16'hCAFE, 16'hA0CF, 16'h0000, 1'b0, 1'b0, 1'b1);
        tick();
        chk("hold_v1", {15'd0, wb_valid}, 16'd0);
        tick();
        chk("hold_v2", {15'd0, wb_valid}, 16'd1);
        chk("hold_d2", wb_data, 16'h7777);
        tick();
        in_valid = 1'b0;
        chk("hold_v3", {15'd0, wb_valid}, 16'd1);
        chk("hold_d3", wb_data, 16'hCAFE);
        tick();
        chk("hold_v4", {15'd0, wb_valid}, 16'd0);

        // Flush in IDLE
        mem_op("pre6", 16'h0006, 16'h2222, 1'b0, 1'b1);
        set_op(16'h0006, 16'hB006, 16'h5555, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        is_branch_takenin = 1'b1;
        tick();
        in_valid = 1'b0;
        is_branch_takenin = 1'b0;
        chk("fl_v",   {15'd0, wb_valid}, 16'd0);
        chk("fl_rdy", {15'd0, in_ready}, 16'd1);
        tick();
        chk("fl_v2",  {15'd0, wb_valid}, 16'd0);
        dbg_addr = 8'd6;
        #1;
        chk("fl_mem6", dbg_data, 16'h2222);

        // Flush during BUSY store
        set_op(16'h0008, 16'hB008, 16'h8888, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        is_branch_takenin = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        is_branch_takenin = 1'b0;
        dbg_addr = 8'd8;
        #1;
        chk("flb_v",    {15'd0, wb_valid}, 16'd1);
        chk("flb_mem8", dbg_data, 16'h8888);

        // Reset mid-BUSY store
        mem_op("pre9", 16'h0009, 16'h1111, 1'b0, 1'b1);
        set_op(16'h0009, 16'hB009, 16'h00AA, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rb_rdy", {15'd0, in_ready}, 16'd1);
        chk("rb_v",   {15'd0, wb_valid}, 16'd0);
        tick();
        #2;
        reset = 1'b1;
        tick();
        chk("rb_v2", {15'd0, wb_valid}, 16'd0);
        tick();
        chk("rb_v3", {15'd0, wb_valid}, 16'd0);
        dbg_addr = 8'd9;
        #1;
        chk("rb_mem9", dbg_data, 16'h1111);

        // isld & isst together behave as a load
        mem_op("pre3", 16'h0003, 16'h3333, 1'b0, 1'b1);
        set_op(16'h0003, 16'hD003, 16'h9999, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        dbg_addr = 8'd3;
        #1;
        chk("ldst_v",    {15'd0, wb_valid}, 16'd1);
        chk("ldst_data", wb_data, 16'h3333);
        chk("ldst_mem3", dbg_data, 16'h3333);

        // MEM_LAT = 1 instance
        set_op(16'h0004, 16'hE004, 16'h4444, 1'b0, 1'b1, 1'b1);
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("l1_st_v0",   {15'd0, wb_valid1}, 16'd0);
        chk("l1_st_rdy0", {15'd0, in_ready1}, 16'd0);
        tick();
        chk("l1_st_v1",   {15'd0, wb_valid1}, 16'd1);
        chk("l1_st_en",   {15'd0, wb_en1},    16'd0);
        chk("l1_st_rdy1", {15'd0, in_ready1}, 16'd1);
        set_op(16'h0004, 16'hE104, 16'h0000, 1'b1, 1'b0, 1'b1);
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("l1_ld_v0", {15'd0, wb_valid1}, 16'd0);
        tick();
        chk("l1_ld_v1", {15'd0, wb_valid1}, 16'd1);
        chk("l1_ld_d",  wb_data1, 16'h4444);
        chk("l1_ld_en", {15'd0, wb_en1}, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
